wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
- Wishbone pipelined single-transfer initiator: drives the bus of register/memory slaves generated in this codebase from a simple valid/ready command port, returning read data and completion status on a response port.
- Used by test sequencers and embedded controllers to access CSR banks.
- Handles stall, ack, err, rty, bounded retries and a cycle timeout.
- One transfer outstanding at a time.

Parameters:
- ADDR_WIDTH, 8, byte-address width; bus carries word address bits [ADDR_WIDTH-1:2].
- TIMEOUT, 255, max cycles from strobe start to termination before abort (1..65535).
- MAX_RETRY, 2, number of reissues allowed after rty.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  ADDR_WIDTH-2  word address
- cmd_sel_i  in  4  byte selects
- cmd_dat_i  in  32  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  32  read data (0 for writes/failures)
- rsp_status_o  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  bus control
- wb_adr_o  out  ADDR_WIDTH-2  word address
- wb_sel_o  out  4  byte selects
- wb_dat_o  out  32  write data
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each  slave termination/flow
- wb_dat_i  in  32  read data

Behaviour:
- Reset (async, immediate): state IDLE; cyc/stb/we=0, adr/sel/dat=0, cmd_ready_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_status_o=00, counters=0. First cmd_ready_o=1 is the cycle after reset release.
- States: IDLE, REQ, WAIT, BACKOFF, RESP.
- IDLE:
  - cmd_ready_o=1; on cmd_valid_i capture we/adr/sel/dat into bus registers, clear timeout and retry counters, go REQ.
  - cyc/stb rise the cycle after acceptance.
- REQ: cyc=stb=1, address/data stable.
  - If wb_stall_i=0: strobe accepted; stb drops next cycle.
  - Termination in the same cycle is evaluated (go to RESP/BACKOFF directly); otherwise go WAIT.
  - If wb_stall_i=1: stay in REQ.
- WAIT: cyc=1, stb=0; stay until a termination or timeout.
- Termination priority when several are asserted in one cycle: err > rty > ack. Terminations are sampled only in REQ-with-stall-low and WAIT; ack/err/rty seen in IDLE/BACKOFF/RESP are ignored.
- On ack: rsp_dat_o = wb_dat_i if read, else 0; status 00; go RESP.
- On err: status 01, rsp_dat_o=0, go RESP.
- On rty:
  - If retry count < MAX_RETRY: increment count, go BACKOFF (cyc=stb=0 for exactly one cycle), then REQ with the same captured command. The timeout counter is cleared on each reissue.
  - Else: status 10, go RESP.
- Timeout:
  - The counter increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no termination that cycle: drop cyc/stb next cycle, status 11, rsp_dat_o=0, go RESP.
  - A termination in the same cycle as the limit wins over the timeout.
- RESP:
  - cyc=stb=0; rsp_valid_o=1 with rsp_dat_o/rsp_status_o held stable until rsp_ready_i; then IDLE.
  - cmd_ready_o=0 (no overlap), so minimum command-to-command spacing is 4 cycles with zero-wait slave.
- Latency, zero-wait slave (no stall, ack the cycle after strobe): command accept T → stb T+1 → ack T+2 → rsp_valid_o T+3.
- cmd_ready_o=0 in all states except IDLE. Bus outputs change only on clock edges.
- Reset mid-transfer: cyc/stb drop asynchronously; any pending response is discarded.

Test Plan:
- Write adr=0x00, dat=0x00000002, sel=0xF, zero-wait ack → exactly one stb cycle with we=1; rsp_valid_o 3 cycles after accept, status 00, rsp_dat_o=0.
- Read adr=0x20, slave stalls 3 cycles, then acks 1 cycle later with 0xDEADBEEF → stb held 4 cycles with stable adr; rsp_dat_o=0xDEADBEEF, status 00.
- Read with rty on the first two attempts, ack on the third (MAX_RETRY=2) → three strobes, each separated by one cyc-low cycle; status 00. Rty on all attempts → three strobes, then status 10.
- err and ack asserted in the same cycle → status 01, rsp_dat_o=0. Slave never responds, TIMEOUT=8 → cyc drops after 8 cycles in REQ/WAIT; status 11.
- Back-to-back commands with rsp_ready_i low for 5 cycles → response held stable, cmd_ready_o=0 throughout; second command accepted the cycle after the handshake.
- rst_i asserted while in WAIT → cyc/stb/rsp_valid_o low immediately; a stray ack after release is ignored; the next command completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command/response port and Wishbone bus bundle
// for the single-transfer Wishbone initiator.
interface wb_cmd_master_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-3:0] cmd_adr_i;
    logic [3:0]            cmd_sel_i;
    logic [31:0]           cmd_dat_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [31:0]           rsp_dat_o;
    logic [1:0]            rsp_status_o;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-3:0] wb_adr_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;
    logic                  wb_stall_i;
    logic [31:0]           wb_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i,
        input  cmd_sel_i, cmd_dat_i, rsp_ready_i,
        input  wb_ack_i, wb_err_i, wb_rty_i,
        input  wb_stall_i, wb_dat_i,
        output cmd_ready_o, rsp_valid_o,
        output rsp_dat_o, rsp_status_o,
        output wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i,
        output cmd_sel_i, cmd_dat_i, rsp_ready_i,
        output wb_ack_i, wb_err_i, wb_rty_i,
        output wb_stall_i, wb_dat_i,
        input  cmd_ready_o, rsp_valid_o,
        input  rsp_dat_o, rsp_status_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_adr_o, wb_sel_o, wb_dat_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined single-transfer initiator:
// stall/ack/err/rty handling, bounded retries, timeout.
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    wb_cmd_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, BACKOFF, RESP
    } state_t;

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);
    localparam logic [7:0]  RTY_LIM = 8'(MAX_RETRY);

    state_t state, state_nxt;

    logic                  started;
    logic [15:0]           tmo_cnt;
    logic [7:0]            rty_cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-3:0] adr_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;
    logic [31:0]           rsp_dat_q;
    logic [1:0]            rsp_st_q;

    logic                  sample;
    logic                  tmo_hit;
    logic                  retry_ok;
    logic                  accept;
    logic [1:0]            st_nxt;
    logic [31:0]           rdat_nxt;

    // Hold off cmd_ready for one cycle after reset release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) started <= 1'b0;
        else       started <= 1'b1;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and response value on termination
    always_comb begin
        state_nxt = state;
        st_nxt    = 2'b00;
        rdat_nxt  = '0;
        accept    = (state == IDLE) && started
                  && bus.cmd_valid_i;
        sample    = (state == WAIT)
                  || ((state == REQ) && !bus.wb_stall_i);
        tmo_hit   = ((state == REQ) || (state == WAIT))
                  && (tmo_cnt == TMO_LIM);
        retry_ok  = rty_cnt < RTY_LIM;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ, WAIT: begin
                if (sample && bus.wb_err_i) begin
                    state_nxt = RESP;
                    st_nxt    = 2'b01;
                end else if (sample && bus.wb_rty_i) begin
                    if (retry_ok) begin
                        state_nxt = BACKOFF;
                    end else begin
                        state_nxt = RESP;
                        st_nxt    = 2'b10;
                    end
                end else if (sample && bus.wb_ack_i) begin
                    state_nxt = RESP;
                    rdat_nxt  = we_q ? 32'h0 : bus.wb_dat_i;
                end else if (tmo_hit) begin
                    state_nxt = RESP;
                    st_nxt    = 2'b11;
                end else if (sample) begin
                    state_nxt = WAIT;
                end
            end
            BACKOFF: state_nxt = REQ;
            RESP: begin
                if (bus.rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Captured command, counters and held response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            tmo_cnt   <= '0;
            rty_cnt   <= '0;
            rsp_dat_q <= '0;
            rsp_st_q  <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.cmd_we_i;
                adr_q   <= bus.cmd_adr_i;
                sel_q   <= bus.cmd_sel_i;
                dat_q   <= bus.cmd_dat_i;
                tmo_cnt <= '0;
                rty_cnt <= '0;
            end
            if ((state == REQ) || (state == WAIT))
                tmo_cnt <= tmo_cnt + 16'd1;
            if (state_nxt == BACKOFF) begin
                rty_cnt <= rty_cnt + 8'd1;
                tmo_cnt <= '0;
            end
            if ((state != RESP) && (state_nxt == RESP)) begin
                rsp_dat_q <= rdat_nxt;
                rsp_st_q  <= st_nxt;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.cmd_ready_o  = (state == IDLE) && started;
        bus.rsp_valid_o  = (state == RESP);
        bus.rsp_dat_o    = rsp_dat_q;
        bus.rsp_status_o = rsp_st_q;
        bus.wb_cyc_o     = (state == REQ) || (state == WAIT);
        bus.wb_stb_o     = (state == REQ);
        bus.wb_we_o      = we_q;
        bus.wb_adr_o     = adr_q;
        bus.wb_sel_o     = sel_q;
        bus.wb_dat_o     = dat_q;
    end
endmodule
